// File: rtl/db9_pad_scanner_if.sv
// Pad-side and result-side signals of the DB9 pad scanner, grouped for the scanner (master) and its environment (slave).
// frame is a one-cycle valid strobe with no ready: the port words are stable from that cycle until the next frame.
interface db9_pad_scanner_if;
  logic        enable;
  logic [5:0]  joy_in;
  logic        joy_mdsel;
  logic        joy_split;
  logic [11:0] joystick1;
  logic [11:0] joystick2;
  logic [1:0]  present;
  logic [1:0]  six_btn;
  logic        frame;
  logic [1:0]  state_dbg;
  logic [2:0]  phase_dbg;

  modport master (
    input  enable, joy_in,
    output joy_mdsel, joy_split, joystick1, joystick2, present, six_btn, frame,
           state_dbg, phase_dbg
  );

  modport slave (
    output enable, joy_in,
    input  joy_mdsel, joy_split, joystick1, joystick2, present, six_btn, frame,
           state_dbg, phase_dbg
  );
endinterface

// File: rtl/db9_pad_scanner.sv
// Scans one or two DB9 (Genesis-style 3/6-button) pads over a shared select line and publishes active-high button words.
// Optional second port: define DB9_SECOND_PORT_EN to alternate scans between port 1 and port 2.
module db9_pad_scanner #(
  parameter int unsigned TICK_DIV    = 400,
  parameter int unsigned IDLE_PHASES = 160
) (
  input logic             clk_sys,
  input logic             reset_n,
  db9_pad_scanner_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SCAN   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] div;
  logic        tick;
  logic [9:0]  idle_cnt;
  logic [2:0]  phase;
  logic [11:0] word;
  logic        pad_ok;
  logic        six;
`ifdef DB9_SECOND_PORT_EN
  logic        next_port;
`endif

  assign tick          = (div == 16'(TICK_DIV - 1));
  assign bus.state_dbg = state;
  assign bus.phase_dbg = phase;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      div           <= '0;
      idle_cnt      <= '0;
      phase         <= '0;
      word          <= '0;
      pad_ok        <= 1'b0;
      six           <= 1'b0;
      bus.joy_mdsel <= 1'b1;
      bus.joy_split <= 1'b1;
      bus.joystick1 <= '0;
      bus.joystick2 <= '0;
      bus.present   <= '0;
      bus.six_btn   <= '0;
      bus.frame     <= 1'b0;
`ifdef DB9_SECOND_PORT_EN
      next_port     <= 1'b1;
`endif
    end else begin
      bus.frame <= 1'b0;
      if (!bus.enable) begin
        // Any partial scan is dropped; the next rise starts with a full idle period.
        state         <= IDLE;
        div           <= '0;
        idle_cnt      <= '0;
        phase         <= '0;
        bus.joy_mdsel <= 1'b1;
      end else begin
        div <= tick ? 16'd0 : div + 16'd1;
        case (state)
          IDLE: begin
            if (tick) begin
              if (idle_cnt == 10'(IDLE_PHASES - 1)) begin
                idle_cnt <= '0;
                state    <= SETTLE;
`ifdef DB9_SECOND_PORT_EN
                bus.joy_split <= next_port;
                next_port     <= ~next_port;
`endif
              end else begin
                idle_cnt <= idle_cnt + 10'd1;
              end
            end
          end
          SETTLE: begin
            if (tick) begin
              state  <= SCAN;
              phase  <= '0;
              word   <= '0;
              pad_ok <= 1'b0;
              six    <= 1'b0;
            end
          end
          SCAN: begin
            if (tick) begin
              // Capture on the last cycle of the phase, before the select line moves.
              case (phase)
                3'd0: word[5:0] <= ~bus.joy_in;
                3'd1: begin
                  word[6] <= ~bus.joy_in[4];
                  word[7] <= ~bus.joy_in[5];
                  pad_ok  <= (bus.joy_in[1:0] == 2'b00);
                end
                3'd5: six <= (bus.joy_in[3:0] == 4'b0000);
                3'd6: if (six) word[11:8] <= ~bus.joy_in[3:0];
                default: ;
              endcase
              if (phase == 3'd7) begin
                state         <= COMMIT;
                bus.joy_mdsel <= 1'b1;
              end else begin
                phase         <= phase + 3'd1;
                bus.joy_mdsel <= phase[0];
              end
            end
          end
          COMMIT: begin
            state     <= IDLE;
            phase     <= '0;
            bus.frame <= 1'b1;
`ifdef DB9_SECOND_PORT_EN
            if (!bus.joy_split) begin
              bus.joystick2  <= pad_ok ? word : 12'h000;
              bus.present[1] <= pad_ok;
              bus.six_btn[1] <= pad_ok & six;
            end else begin
              bus.joystick1  <= pad_ok ? word : 12'h000;
              bus.present[0] <= pad_ok;
              bus.six_btn[0] <= pad_ok & six;
            end
`else
            bus.joystick1  <= pad_ok ? word : 12'h000;
            bus.present[0] <= pad_ok;
            bus.six_btn[0] <= pad_ok & six;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/db9_pad_scanner.md
DB9_PAD_SCANNER -- requirements
Module: db9_pad_scanner

Interface
REQ-001 Parameter TICK_DIV, default 400, clk_sys cycles per scan phase (10 us at 40 MHz); legal range 2..65535.
REQ-002 Parameter IDLE_PHASES, default 160, idle phases between port scans (1.6 ms at default), so the pad's 6-button counter resets; legal range 1..1023.
REQ-003 clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  scanning permitted while high.
REQ-006 joy_in  in  6  pad pins, active-low: [0]R [1]L [2]D [3]U [4]pin6 (B when select high, A when low) [5]pin9 (C when select high, Start when low).
REQ-007 joy_mdsel  out  1  pad select line driven to the shared connector.
REQ-008 joy_split  out  1  port mux select: 1 = port 1, 0 = port 2.
REQ-009 joystick1, joystick2  out  12 each  active-high words: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start [8]Mode [9]X [10]Y [11]Z.
REQ-010 present  out  2  [0] pad detected on port 1, [1] on port 2.
REQ-011 six_btn  out  2  per-port 6-button pad detected.
REQ-012 frame  out  1  one-cycle pulse when a port result commits.

Function
REQ-013 Phase tick: a 16-bit divider counts 0..TICK_DIV-1 and wraps; the tick is the cycle the count equals TICK_DIV-1.
REQ-014 States: IDLE -> SETTLE -> SCAN -> COMMIT -> IDLE; each transition occurs only on a tick, except COMMIT, which lasts exactly one cycle.
REQ-015 IDLE: joy_mdsel=1; remains for IDLE_PHASES ticks; on exit, joy_split moves to the next port.
REQ-016 SETTLE: one phase with joy_mdsel=1 and the new joy_split; no sampling.
REQ-017 SCAN: phase index p runs 0..7; joy_mdsel=1 for even p and 0 for odd p; the level changes in the cycle after the tick.
REQ-018 Sampling: joy_in is captured on the tick cycle ending each phase, before joy_mdsel changes.
REQ-019 p=0 captures U,D,L,R,B,C.
REQ-020 p=1 captures A and Start; pad is present iff joy_in[1:0]==2'b00 in this sample.
REQ-021 p=5 flags six-button iff joy_in[3:0]==4'b0000.
REQ-022 p=6, when six-button, captures Z=~in[3], Y=~in[2], X=~in[1], Mode=~in[0]; otherwise bits [11:8] are 0.
REQ-023 COMMIT writes the port's word, present bit and six_btn bit together and pulses frame.
REQ-024 A port with no pad present commits word 12'h000 and six_btn 0.
REQ-025 Outputs never change outside COMMIT.
REQ-026 enable low: the FSM returns to IDLE at the next cycle, the divider clears, joy_mdsel=1, joy_split holds, and outputs keep their last values.
REQ-027 enable rising: the scan restarts with a full IDLE_PHASES idle period.
REQ-028 A partial scan aborted by enable is discarded and never committed.

Reset
REQ-029 While reset_n is low: joystick1=joystick2=12'h000, present=six_btn=2'b00, frame=0, joy_mdsel=1, joy_split=1, state IDLE, divider 0, p 0.
REQ-030 Reset asserted mid-scan aborts the scan immediately; the first scan after release targets port 1 after a full idle period.

Configuration
REQ-031 With DB9_SECOND_PORT_EN defined: ports alternate 1,2,1,2 after each IDLE.
REQ-032 Without DB9_SECOND_PORT_EN: joy_split is constant 1; only port 1 is scanned; joystick2, present[1] and six_btn[1] are constant 0.

Verification
REQ-033 TICK_DIV=4, IDLE_PHASES=2, 3-button pad model on port 1 holding Right+Start -> frame pulses; joystick1=12'h081, present[0]=1, six_btn[0]=0.
REQ-034 6-button pad model on port 2 holding X+Z+A (DB9_SECOND_PORT_EN defined) -> joystick2=12'hA40, six_btn[1]=1; joystick1 is unchanged across that commit.
REQ-035 joy_in held 6'h3F (no pad) -> commit with word 12'h000 and present bit 0; joy_mdsel toggles exactly 4 times low per scan.
REQ-036 enable dropped at p=3 then raised -> no frame pulse for the aborted scan; the next commit comes 2+1+8 ticks after the rise.
REQ-037 reset_n pulsed low at p=6 -> all outputs at reset values asynchronously; joy_split=1 on the first SETTLE after release.
REQ-038 DB9_SECOND_PORT_EN undefined over 4 scans -> joy_split constant 1, joystick2 constant 0, four frame pulses.
